// File: rtl/gpu_loader_pkg.sv
// Shared types for the GPU loader: controller states, completion status codes
// and the saturating cycle-counter helper.
package gpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INST_REQ,
        INST_WAIT,
        DATA_REQ,
        DATA_WAIT,
        RUN,
        FINISH
    } state_t;

    localparam logic [1:0] STATUS_HALTED    = 2'b00;
    localparam logic [1:0] STATUS_EXCEPTION = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT   = 2'b10;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/gpu_loader_reader.sv
// Single-outstanding Avalon read engine shared by the instruction and data
// load phases; turns each accepted read into one registered RAM write pulse.
module gpu_loader_reader
    import gpu_loader_pkg::*;
#(
    parameter int WORD_WIDTH          = 32,
    parameter int ADDRESS_WIDTH       = 16,
    parameter int SDRAM_ADDRESS_WIDTH = 24
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           issue,
    input  logic                           collect,
    input  logic [SDRAM_ADDRESS_WIDTH-1:0] base,
    input  logic [ADDRESS_WIDTH-1:0]       index,
    output logic                           sdram_read,
    output logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_address,
    input  logic                           sdram_waitrequest,
    input  logic [WORD_WIDTH-1:0]          sdram_readdata,
    input  logic                           sdram_readdatavalid,
    output logic                           accepted,
    output logic                           write_pulse,
    output logic [ADDRESS_WIDTH-1:0]       write_address,
    output logic [WORD_WIDTH-1:0]          write_data
);

    logic capture;

    assign sdram_read    = issue;
    assign sdram_address = issue ? base + SDRAM_ADDRESS_WIDTH'(index) : '0;
    assign accepted      = issue & ~sdram_waitrequest;

    // Only the first response in a wait phase counts; the write cycle itself
    // still sits in the wait state, so anything arriving then is dropped.
    assign capture = collect & sdram_readdatavalid & ~write_pulse;

    always_ff @(posedge clock) begin
        if (reset) begin
            write_pulse   <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            write_pulse <= capture;
            if (capture) begin
                write_address <= {index[ADDRESS_WIDTH-3:0], 2'b00};
                write_data    <= sdram_readdata;
            end
        end
    end

endmodule

// File: rtl/gpu_loader.sv
// Loads instruction and data images from SDRAM into GPU RAMs, runs the GPU and
// reports how it stopped. Define GPU_LOADER_TIMEOUT_EN to add the run watchdog.
module gpu_loader
    import gpu_loader_pkg::*;
#(
    parameter int WORD_WIDTH          = 32,
    parameter int ADDRESS_WIDTH       = 16,
    parameter int SDRAM_ADDRESS_WIDTH = 24,
    parameter int TIMEOUT_CYCLES      = 1000000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [SDRAM_ADDRESS_WIDTH-1:0] inst_base,
    input  logic [SDRAM_ADDRESS_WIDTH-1:0] data_base,
    input  logic [ADDRESS_WIDTH-1:0]       inst_words,
    input  logic [ADDRESS_WIDTH-1:0]       data_words,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [31:0]                    run_cycles,
    output logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_address,
    output logic                           sdram_read,
    input  logic                           sdram_waitrequest,
    input  logic [WORD_WIDTH-1:0]          sdram_readdata,
    input  logic                           sdram_readdatavalid,
    output logic                           gpu_run,
    input  logic                           gpu_halted,
    input  logic                           gpu_exception,
    output logic                           ext_enable_write_inst_ram,
    output logic [ADDRESS_WIDTH-1:0]       ext_inst_ram_address,
    output logic [WORD_WIDTH-1:0]          ext_inst_ram_input,
    output logic                           ext_enable_write_data_ram,
    output logic [ADDRESS_WIDTH-1:0]       ext_data_ram_address,
    output logic [WORD_WIDTH-1:0]          ext_data_ram_input
);

    localparam logic [ADDRESS_WIDTH-1:0] MAX_WORDS = ADDRESS_WIDTH'(1) << (ADDRESS_WIDTH - 2);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic [ADDRESS_WIDTH-1:0] clamp_count(input logic [ADDRESS_WIDTH-1:0] n);
        return (n > MAX_WORDS) ? MAX_WORDS : n;
    endfunction

    state_t                         state;
    logic [SDRAM_ADDRESS_WIDTH-1:0] inst_base_q;
    logic [SDRAM_ADDRESS_WIDTH-1:0] data_base_q;
    logic [ADDRESS_WIDTH-1:0]       inst_count;
    logic [ADDRESS_WIDTH-1:0]       data_count;
    logic [ADDRESS_WIDTH-1:0]       index;

    logic                           issue;
    logic                           collect;
    logic                           in_inst;
    logic                           accepted;
    logic                           write_pulse;
    logic [ADDRESS_WIDTH-1:0]       write_address;
    logic [WORD_WIDTH-1:0]          write_data;

    assign issue   = (state == INST_REQ)  || (state == DATA_REQ);
    assign collect = (state == INST_WAIT) || (state == DATA_WAIT);
    assign in_inst = (state == INST_REQ)  || (state == INST_WAIT);

    gpu_loader_reader #(
        .WORD_WIDTH          (WORD_WIDTH),
        .ADDRESS_WIDTH       (ADDRESS_WIDTH),
        .SDRAM_ADDRESS_WIDTH (SDRAM_ADDRESS_WIDTH)
    ) reader (
        .clock               (clock),
        .reset               (reset),
        .issue               (issue),
        .collect             (collect),
        .base                (in_inst ? inst_base_q : data_base_q),
        .index               (index),
        .sdram_read          (sdram_read),
        .sdram_address       (sdram_address),
        .sdram_waitrequest   (sdram_waitrequest),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .accepted            (accepted),
        .write_pulse         (write_pulse),
        .write_address       (write_address),
        .write_data          (write_data)
    );

    // The write pulse is emitted while the FSM is still in the phase's wait state.
    assign ext_enable_write_inst_ram = write_pulse & (state == INST_WAIT);
    assign ext_enable_write_data_ram = write_pulse & (state == DATA_WAIT);
    assign ext_inst_ram_address      = write_address;
    assign ext_inst_ram_input        = write_data;
    assign ext_data_ram_address      = write_address;
    assign ext_data_ram_input        = write_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= STATUS_HALTED;
            run_cycles  <= '0;
            gpu_run     <= 1'b0;
            index       <= '0;
            inst_base_q <= '0;
            data_base_q <= '0;
            inst_count  <= '0;
            data_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        inst_base_q <= inst_base;
                        data_base_q <= data_base;
                        inst_count  <= clamp_count(inst_words);
                        data_count  <= clamp_count(data_words);
                        index       <= '0;
                        busy        <= 1'b1;
                        status      <= STATUS_HALTED;
                        run_cycles  <= '0;
                        if (inst_words != '0) begin
                            state <= INST_REQ;
                        end else if (data_words != '0) begin
                            state <= DATA_REQ;
                        end else begin
                            state   <= RUN;
                            gpu_run <= 1'b1;
                        end
                    end
                end
                INST_REQ: begin
                    if (accepted) state <= INST_WAIT;
                end
                INST_WAIT: begin
                    if (write_pulse) begin
                        if (index == inst_count - 1'b1) begin
                            index <= '0;
                            if (data_count != '0) begin
                                state <= DATA_REQ;
                            end else begin
                                state   <= RUN;
                                gpu_run <= 1'b1;
                            end
                        end else begin
                            index <= index + 1'b1;
                            state <= INST_REQ;
                        end
                    end
                end
                DATA_REQ: begin
                    if (accepted) state <= DATA_WAIT;
                end
                DATA_WAIT: begin
                    if (write_pulse) begin
                        if (index == data_count - 1'b1) begin
                            index   <= '0;
                            state   <= RUN;
                            gpu_run <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= DATA_REQ;
                        end
                    end
                end
                RUN: begin
                    run_cycles <= sat_inc32(run_cycles);
                    // run_cycles is still zero during the first RUN cycle, which masks GPU status.
                    if ((run_cycles != '0) && (gpu_halted || gpu_exception)) begin
                        state   <= FINISH;
                        gpu_run <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        status  <= gpu_exception ? STATUS_EXCEPTION : STATUS_HALTED;
                    end
`ifdef GPU_LOADER_TIMEOUT_EN
                    else if (run_cycles >= 32'(TIMEOUT_CYCLES - 1)) begin
                        state   <= FINISH;
                        gpu_run <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        status  <= STATUS_TIMEOUT;
                    end
`endif
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_loader.sv
// Table-driven bench for gpu_loader with an SDRAM responder, a GPU model and a
// write scoreboard; also runs reset and watchdog sequences.
`timescale 1ns/1ps
module tb_gpu_loader;
    import gpu_loader_pkg::*;

    localparam int WW  = 32;
    localparam int AW  = 16;
    localparam int SAW = 24;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [SAW-1:0] inst_base = '0;
    logic [SAW-1:0] data_base = '0;
    logic [AW-1:0]  inst_words = '0;
    logic [AW-1:0]  data_words = '0;
    logic           busy, done, sdram_read, gpu_run;
    logic [1:0]     status;
    logic [31:0]    run_cycles;
    logic [SAW-1:0] sdram_address;
    logic           sdram_waitrequest = 1'b0;
    logic [WW-1:0]  sdram_readdata = '0;
    logic           sdram_readdatavalid = 1'b0;
    logic           gpu_halted = 1'b0;
    logic           gpu_exception = 1'b0;
    logic           inst_we, data_we;
    logic [AW-1:0]  inst_addr, data_addr;
    logic [WW-1:0]  inst_data, data_data;

    always #5 clock = ~clock;

    gpu_loader #(
        .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .SDRAM_ADDRESS_WIDTH(SAW), .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .inst_base(inst_base), .data_base(data_base),
        .inst_words(inst_words), .data_words(data_words),
        .busy(busy), .done(done), .status(status), .run_cycles(run_cycles),
        .sdram_address(sdram_address), .sdram_read(sdram_read),
        .sdram_waitrequest(sdram_waitrequest), .sdram_readdata(sdram_readdata),
        .sdram_readdatavalid(sdram_readdatavalid),
        .gpu_run(gpu_run), .gpu_halted(gpu_halted), .gpu_exception(gpu_exception),
        .ext_enable_write_inst_ram(inst_we), .ext_inst_ram_address(inst_addr),
        .ext_inst_ram_input(inst_data),
        .ext_enable_write_data_ram(data_we), .ext_data_ram_address(data_addr),
        .ext_data_ram_input(data_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [SAW-1:0] a);
        return {8'hD0, a} ^ 32'h0F5A_3C96;
    endfunction

    // SDRAM responder: programmable waitrequest count, response latency, stray valids.
    int             wait_cfg = 0, lat_cfg = 0, stray_en = 0;
    int             wait_ctr = 0, resp_delay = 0, reads_accepted = 0;
    bit             resp_pending = 0, prev_wait = 0;
    logic [SAW-1:0] resp_addr = '0, prev_addr = '0;

    always @(negedge clock) begin
        sdram_readdatavalid = 1'b0;
        sdram_readdata      = '0;
        if (resp_pending) begin
            if (resp_delay == 0) begin
                sdram_readdatavalid = 1'b1;
                sdram_readdata      = pattern(resp_addr);
                resp_pending        = 0;
            end else begin
                resp_delay--;
            end
        end
        if (sdram_read) begin
            if (prev_wait) check("addr_stable", sdram_address, prev_addr);
            check("one_outstanding", resp_pending | sdram_readdatavalid, 0);
            prev_addr = sdram_address;
            if (wait_ctr < wait_cfg) begin
                sdram_waitrequest = 1'b1;
                wait_ctr++;
                prev_wait = 1;
                if (stray_en != 0) begin
                    sdram_readdatavalid = 1'b1;
                    sdram_readdata      = 32'hDEAD_BEEF;
                end
            end else begin
                sdram_waitrequest = 1'b0;
                wait_ctr          = 0;
                prev_wait         = 0;
                resp_pending      = 1;
                resp_delay        = lat_cfg;
                resp_addr         = sdram_address;
                reads_accepted++;
            end
        end else begin
            sdram_waitrequest = 1'b0;
            prev_wait         = 0;
        end
    end

    // GPU model: status asserted (and held) from run cycle halt_at onward; 0 = never.
    int halt_at = 0, halt_kind = 0, run_cnt = 0;

    always @(posedge clock) begin
        if (start && !busy) run_cnt <= 0;
        else if (gpu_run)   run_cnt <= run_cnt + 1;
    end

    always @(negedge clock) begin
        gpu_halted    = 1'b0;
        gpu_exception = 1'b0;
        if (gpu_run && halt_at != 0 && run_cnt + 1 >= halt_at) begin
            gpu_halted    = (halt_kind != 1);
            gpu_exception = (halt_kind != 0);
        end
    end

    // Write scoreboard.
    typedef struct packed {
        logic          is_inst;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;
    wr_t expq[$];
    int  writes_seen = 0;
    bit  prev_we = 0, prev_run = 0, run_after_write = 0;

    always @(negedge clock) begin
        wr_t e;
        if (inst_we || data_we) begin
            writes_seen++;
            check("write_exclusive", {inst_we & data_we, gpu_run}, 0);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: inst=%0b addr=0x%0h data=0x%0h, expected no write",
                         inst_we, inst_we ? inst_addr : data_addr, inst_we ? inst_data : data_data);
            end else begin
                e = expq.pop_front();
                check("write_port", inst_we, e.is_inst);
                check("write_addr", inst_we ? inst_addr : data_addr, e.addr);
                check("write_data", inst_we ? inst_data : data_data, e.data);
            end
        end
        if (gpu_run && !prev_run && run_after_write) check("run_after_last_write", prev_we, 1);
        prev_we  = inst_we | data_we;
        prev_run = gpu_run;
    end

    task automatic check_reset_outputs(input string name);
        check(name, {busy, done, status, run_cycles, sdram_read, sdram_address, gpu_run,
                     inst_we, inst_addr, inst_data, data_we, data_addr, data_data}, 0);
    endtask

    typedef struct {
        int         iw;
        int         dw;
        logic [SAW-1:0] ib;
        logic [SAW-1:0] db;
        int         wt;
        int         lat;
        int         halt;
        int         kind;
        int         stray;
        int         poke;
        logic [1:0] st;
        int         rc;
    } vec_t;

    task automatic pulse_start(input vec_t v);
        @(negedge clock);
        start      = 1'b1;
        inst_base  = v.ib;
        data_base  = v.db;
        inst_words = AW'(v.iw);
        data_words = AW'(v.dw);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input int idx);
        wr_t e;
        int  ni, nd, reads0, writes0, budget;
        bit  seen;
        ni = (v.iw > 16384) ? 16384 : v.iw;
        nd = (v.dw > 16384) ? 16384 : v.dw;
        for (int i = 0; i < ni; i++) begin
            e.is_inst = 1'b1; e.addr = AW'(i * 4); e.data = pattern(v.ib + SAW'(i));
            expq.push_back(e);
        end
        for (int i = 0; i < nd; i++) begin
            e.is_inst = 1'b0; e.addr = AW'(i * 4); e.data = pattern(v.db + SAW'(i));
            expq.push_back(e);
        end
        wait_cfg = v.wt; lat_cfg = v.lat; stray_en = v.stray;
        halt_at = v.halt; halt_kind = v.kind;
        run_after_write = (ni + nd) > 0;
        reads0  = reads_accepted;
        writes0 = writes_seen;
        pulse_start(v);
        check($sformatf("v%0d_busy_after_start", idx), busy, 1);
        if (ni + nd == 0) check($sformatf("v%0d_run_immediate", idx), gpu_run, 1);
        budget = (ni + nd) * (v.wt + v.lat + 4) + 200;
        seen   = 0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            start = (v.poke != 0 && k == v.poke);
            if (start) begin
                inst_base = 24'hABCDEF; data_base = 24'h123456;
                inst_words = 16'd5;     data_words = 16'd5;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check($sformatf("v%0d_done_seen", idx), seen, 1);
        check($sformatf("v%0d_status", idx), status, v.st);
        check($sformatf("v%0d_run_cycles", idx), run_cycles, v.rc);
        check($sformatf("v%0d_busy_with_done", idx), {busy, gpu_run}, 0);
        check($sformatf("v%0d_writes_left", idx), expq.size(), 0);
        check($sformatf("v%0d_reads", idx), reads_accepted - reads0, ni + nd);
        check($sformatf("v%0d_writes", idx), writes_seen - writes0, ni + nd);
        expq.delete();
        @(negedge clock);
        check($sformatf("v%0d_done_one_cycle", idx), done, 0);
        check($sformatf("v%0d_status_held", idx), {status, run_cycles}, {v.st, 32'(v.rc)});
        run_after_write = 0;
    endtask

    vec_t vecs[7];
    vec_t v;
    bit   found;
    int   writes0;

    initial begin
        //          iw      dw  ib          db         wt lat halt kind stray poke st     rc
        vecs[0] = '{3,      2,  24'h000100, 24'h000200, 0, 0, 5, 0, 0, 0, 2'b00, 5};
        vecs[1] = '{4,      3,  24'h000300, 24'h000040, 4, 3, 3, 1, 0, 7, 2'b01, 3};
        vecs[2] = '{0,      0,  24'h000000, 24'h000000, 0, 0, 2, 2, 0, 0, 2'b01, 2};
        vecs[3] = '{2,      0,  24'h000010, 24'h000000, 1, 1, 1, 0, 0, 0, 2'b00, 2};
        vecs[4] = '{0,      3,  24'h000000, 24'h000500, 2, 0, 4, 0, 1, 0, 2'b00, 4};
        vecs[5] = '{2,      1,  24'hFFFFFF, 24'h000007, 0, 2, 2, 1, 0, 0, 2'b01, 2};
        vecs[6] = '{16'hFFFF, 0, 24'h001000, 24'h000000, 0, 0, 3, 0, 0, 0, 2'b00, 3};

        repeat (3) @(negedge clock);
        check_reset_outputs("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_job(vecs[i], i);

        // Reset while a read response is outstanding; the late response must not write.
        wait_cfg = 0; lat_cfg = 6; stray_en = 0; halt_at = 0;
        v = '{2, 0, 24'h000040, 24'h0, 0, 6, 0, 0, 0, 0, 2'b00, 0};
        pulse_start(v);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (resp_pending && !sdram_read) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        check("inst_wait_reached", found, 1);
        writes0 = writes_seen;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("reset_in_inst_wait");
        repeat (12) @(negedge clock);
        check("late_response_no_write", writes_seen - writes0, 0);
        check("idle_after_late_response", {busy, sdram_read, gpu_run}, 0);

        // Reset during RUN.
        v = '{0, 0, 24'h0, 24'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0};
        pulse_start(v);
        repeat (4) @(negedge clock);
        check("running_before_reset", {busy, gpu_run}, 2'b11);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("reset_in_run");
        repeat (3) @(negedge clock);
        check("idle_after_run_reset", {busy, gpu_run, done}, 0);

`ifdef GPU_LOADER_TIMEOUT_EN
        v = '{0, 0, 24'h0, 24'h0, 0, 0, 0, 0, 0, 0, 2'b10, 50};
        run_job(v, 7);
`else
        v = '{0, 0, 24'h0, 24'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0};
        halt_at = 0;
        pulse_start(v);
        found = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (done) found = 1;
        end
        check("no_watchdog_done", found, 0);
        check("no_watchdog_running", {busy, gpu_run}, 2'b11);
        check("no_watchdog_run_cycles", run_cycles, 1000);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
`endif

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpu_loader.md
GPU_LOADER -- requirements
Module: gpu_loader

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, 32, data word width; ADDRESS_WIDTH, 16, GPU RAM byte-address width; SDRAM_ADDRESS_WIDTH, 24, SDRAM word-address width; TIMEOUT_CYCLES, 1000000, run watchdog limit.
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle load-and-run request.
- inst_base / data_base  in  SDRAM_ADDRESS_WIDTH  SDRAM word address of each image.
- inst_words / data_words  in  ADDRESS_WIDTH  image length in words.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 halted, 01 exception, 10 timeout.
- run_cycles  out  32  cycles gpu_run was high in the last job.
- sdram_address  out  SDRAM_ADDRESS_WIDTH  read address.
- sdram_read  out  1  Avalon read request.
- sdram_waitrequest, sdram_readdata, sdram_readdatavalid  in  1 / WORD_WIDTH / 1  Avalon read response.
- gpu_run  out  1  GPU run enable.
- gpu_halted, gpu_exception  in  1  GPU status.
- ext_enable_write_inst_ram, ext_inst_ram_address, ext_inst_ram_input  out  1 / ADDRESS_WIDTH / WORD_WIDTH  GPU instruction RAM load port.
- ext_enable_write_data_ram, ext_data_ram_address, ext_data_ram_input  out  same widths  GPU data RAM load port.

Function
REQ-003 SHALL use states IDLE, INST_REQ, INST_WAIT, DATA_REQ, DATA_WAIT, RUN, FINISH.
REQ-004 In IDLE, start=1 SHALL latch bases and counts, then go to INST_REQ; INST_REQ/INST_WAIT are skipped when inst_words=0, and DATA_REQ/DATA_WAIT are skipped when data_words=0.
REQ-005 Counts above 2^(ADDRESS_WIDTH-2) SHALL be clamped to 2^(ADDRESS_WIDTH-2).
REQ-006 start while busy SHALL be ignored.
REQ-007 In *_REQ, sdram_read=1 and sdram_address=base+index SHALL hold until a cycle with sdram_waitrequest=0, then the state moves to *_WAIT.
REQ-008 At most one read SHALL be outstanding.
REQ-009 In *_WAIT, the cycle with sdram_readdatavalid=1 SHALL produce, on the next cycle, a single-cycle write pulse with address = index<<2 (byte address, low bits 00) and data = captured readdata.
REQ-010 After the REQ-009 write, the index SHALL increment; the next state is *_REQ, or the next phase after the last word.
REQ-011 sdram_readdatavalid outside *_WAIT SHALL be ignored.
REQ-012 sdram_read SHALL be 0 outside *_REQ, and ext write enables SHALL be 0 except the REQ-009 pulse.
REQ-013 gpu_run SHALL be 0 in every state except RUN.
REQ-014 RUN SHALL assert gpu_run starting the cycle after the last RAM write.
REQ-015 gpu_halted and gpu_exception SHALL be ignored in the first RUN cycle.
REQ-016 From the second RUN cycle, gpu_halted or gpu_exception high SHALL end RUN; exception wins when both are high (status 01).
REQ-017 run_cycles SHALL clear on start and increment every cycle gpu_run=1; it saturates at 2^32-1.
REQ-018 FINISH SHALL last one cycle, with gpu_run=0, done=1, and status valid; it then returns to IDLE.
REQ-019 busy SHALL fall in the same cycle done is high.
REQ-020 status and run_cycles SHALL hold until the next accepted start.

Reset
REQ-021 reset SHALL force IDLE in the next cycle from any state, including mid-read and mid-run.
REQ-022 Reset values SHALL be: busy=0, done=0, status=00, run_cycles=0, sdram_read=0, gpu_run=0, and all ext write enables, addresses and data = 0.
REQ-023 A read response arriving after reset SHALL be discarded.

Configuration
REQ-024 With GPU_LOADER_TIMEOUT_EN defined, RUN SHALL end with status 10 when run_cycles reaches TIMEOUT_CYCLES and neither halted nor exception is high in that cycle.
REQ-025 Without GPU_LOADER_TIMEOUT_EN, there SHALL be no watchdog logic, status 10 is never produced, and RUN waits indefinitely.

Structure
REQ-026 The shared package gpu_loader_pkg SHALL hold the state enum and the status codes (STATUS_HALTED, STATUS_EXCEPTION, STATUS_TIMEOUT).
REQ-027 The single-read Avalon handshake (REQ-007/009/011) SHALL be one sub-module, gpu_loader_reader, instantiated once and shared by both load phases.

Verification
REQ-028 Directed scenarios:
- inst_words=3 at base 0x100, data_words=2 at 0x200, zero-wait SDRAM, halted at run cycle 5 -> writes at inst addresses 0,4,8 and data addresses 0,4 with correct words; done pulse; status=00; run_cycles=5.
- waitrequest held 4 cycles, readdatavalid delayed 3 cycles per read -> sdram_address stable while waiting, exactly one write per word, no duplicate reads.
- inst_words=0, data_words=0 -> gpu_run rises the cycle after start is latched; both halted and exception high on run cycle 2 -> status=01.
- start pulsed again mid-load, and stray readdatavalid in DATA_REQ -> both ignored, RAM contents unchanged.
- reset asserted during RUN and during INST_WAIT -> next cycle gpu_run=0, sdram_read=0, busy=0, outputs at reset values; a late readdatavalid causes no write.
- GPU_LOADER_TIMEOUT_EN defined with TIMEOUT_CYCLES=50 and GPU never halting -> done with status=10 and run_cycles=50; without the macro, still busy after 1000 cycles.
